acc_x_c_adapter: RTL and testbench

- Sits between the core-side extension (X) bus and the accelerator-side C bus.
- Predecodes each offloaded instruction against NumAcc accelerator predecoders. Answers accept/writeback on the X acknowledge channel.
- Registers accepted requests onto the C request channel with the target address, and registers C responses back onto the X response channel.
- Limits outstanding write-back offloads to MaxOutstanding.

---
 rtl/acc_x_c_adapter.sv | 191 +++++++++++++++++++
 tb/tb_acc_x_c_adapter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_x_c_adapter.sv
// Bridge from the core-side X extension bus to the accelerator-side C bus.
// Predecodes offloads, registers C requests and X responses, and bounds write-backs in flight.
module acc_x_c_adapter #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumAcc         = 4,
    parameter int unsigned AddrWidth      = (NumAcc > 1) ? $clog2(NumAcc) : 1,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            hart_id_i,

    input  logic [31:0]            x_q_instr_data,
    input  logic [DataWidth-1:0]   x_q_rs1,
    input  logic [DataWidth-1:0]   x_q_rs2,
    input  logic [DataWidth-1:0]   x_q_rs3,
    input  logic [2:0]             x_q_rs_valid,
    input  logic [1:0]             x_q_rd_clean,
    input  logic                   x_q_valid,
    output logic                   x_q_ready,
    output logic                   x_k_accept,
    output logic [1:0]             x_k_writeback,

    output logic [DataWidth-1:0]   x_p_data0,
    output logic [DataWidth-1:0]   x_p_data1,
    output logic                   x_p_dual_writeback,
    output logic [4:0]             x_p_rd,
    output logic                   x_p_error,
    output logic                   x_p_valid,
    input  logic                   x_p_ready,

    output logic [31:0]            prd_q_instr_data,
    input  logic [NumAcc-1:0]      prd_p_accept,
    input  logic [2*NumAcc-1:0]    prd_p_writeback,
    input  logic [3*NumAcc-1:0]    prd_p_use_rs,

    output logic [AddrWidth-1:0]   c_q_addr,
    output logic [31:0]            c_q_data_op,
    output logic [DataWidth-1:0]   c_q_data_arga,
    output logic [DataWidth-1:0]   c_q_data_argb,
    output logic [DataWidth-1:0]   c_q_data_argc,
    output logic [31:0]            c_q_hart_id,
    output logic                   c_q_valid,
    input  logic                   c_q_ready,

    input  logic [DataWidth-1:0]   c_p_data0,
    input  logic [DataWidth-1:0]   c_p_data1,
    input  logic                   c_p_dual_writeback,
    input  logic [31:0]            c_p_hart_id,
    input  logic [4:0]             c_p_rd,
    input  logic                   c_p_error,
    input  logic                   c_p_valid,
    output logic                   c_p_ready
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic                 any_acc;
    logic [AddrWidth-1:0] sel;
    logic [1:0]           wb;
    logic [2:0]           use_rs;
    logic                 req_free;
    logic                 accept;
    logic                 cnt_inc;
    logic                 cnt_dec;
    logic                 rsp_load;

    logic [AddrWidth-1:0] c_q_addr_reg;
    logic [31:0]          c_q_data_op_reg;
    logic [DataWidth-1:0] c_q_arga_reg;
    logic [DataWidth-1:0] c_q_argb_reg;
    logic [DataWidth-1:0] c_q_argc_reg;
    logic [31:0]          c_q_hart_id_reg;
    logic                 c_q_valid_reg;

    logic [DataWidth-1:0] x_p_data0_reg;
    logic [DataWidth-1:0] x_p_data1_reg;
    logic                 x_p_dual_reg;
    logic [4:0]           x_p_rd_reg;
    logic                 x_p_error_reg;
    logic                 x_p_valid_reg;

    logic [CntWidth-1:0]  outstanding_reg;

    // Scan from the top down so the lowest accepting predecoder is the last to assign.
    always_comb begin
        any_acc = 1'b0;
        sel     = '0;
        wb      = 2'b00;
        use_rs  = 3'b000;
        for (int i = int'(NumAcc) - 1; i >= 0; i--) begin
            if (prd_p_accept[i]) begin
                any_acc = 1'b1;
                sel     = AddrWidth'(i);
                wb      = prd_p_writeback[2*i +: 2];
                use_rs  = prd_p_use_rs[3*i +: 3];
            end
        end
    end

    assign req_free = !c_q_valid_reg || c_q_ready;
    assign accept   = any_acc && x_q_valid
                    && ((x_q_rs_valid & use_rs) == use_rs)
                    && ((x_q_rd_clean & wb) == wb)
                    && req_free
                    && ((wb == 2'b00) || (outstanding_reg < MaxCnt));

    // Offloads that no accelerator claims are rejected in the same cycle.
    assign x_q_ready     = accept || !any_acc;
    assign x_k_accept    = accept;
    assign x_k_writeback = accept ? wb : 2'b00;

    assign prd_q_instr_data = x_q_instr_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q_valid_reg   <= 1'b0;
            c_q_addr_reg    <= '0;
            c_q_data_op_reg <= '0;
            c_q_arga_reg    <= '0;
            c_q_argb_reg    <= '0;
            c_q_argc_reg    <= '0;
            c_q_hart_id_reg <= '0;
        end else if (accept) begin
            c_q_valid_reg   <= 1'b1;
            c_q_addr_reg    <= sel;
            c_q_data_op_reg <= x_q_instr_data;
            c_q_arga_reg    <= x_q_rs1;
            c_q_argb_reg    <= x_q_rs2;
            c_q_argc_reg    <= x_q_rs3;
            c_q_hart_id_reg <= hart_id_i;
        end else if (c_q_ready) begin
            c_q_valid_reg   <= 1'b0;
        end
    end

    assign c_q_valid     = c_q_valid_reg;
    assign c_q_addr      = c_q_addr_reg;
    assign c_q_data_op   = c_q_data_op_reg;
    assign c_q_data_arga = c_q_arga_reg;
    assign c_q_data_argb = c_q_argb_reg;
    assign c_q_data_argc = c_q_argc_reg;
    assign c_q_hart_id   = c_q_hart_id_reg;

    // Responses for another hart are still consumed so they cannot block the C bus.
    assign c_p_ready = !x_p_valid_reg || x_p_ready;
    assign rsp_load  = c_p_valid && c_p_ready && (c_p_hart_id == hart_id_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_p_valid_reg <= 1'b0;
            x_p_data0_reg <= '0;
            x_p_data1_reg <= '0;
            x_p_dual_reg  <= 1'b0;
            x_p_rd_reg    <= '0;
            x_p_error_reg <= 1'b0;
        end else if (rsp_load) begin
            x_p_valid_reg <= 1'b1;
            x_p_data0_reg <= c_p_data0;
            x_p_data1_reg <= c_p_data1;
            x_p_dual_reg  <= c_p_dual_writeback;
            x_p_rd_reg    <= c_p_rd;
            x_p_error_reg <= c_p_error;
        end else if (x_p_ready) begin
            x_p_valid_reg <= 1'b0;
        end
    end

    assign x_p_valid          = x_p_valid_reg;
    assign x_p_data0          = x_p_data0_reg;
    assign x_p_data1          = x_p_data1_reg;
    assign x_p_dual_writeback = x_p_dual_reg;
    assign x_p_rd             = x_p_rd_reg;
    assign x_p_error          = x_p_error_reg;

    assign cnt_inc = accept && (wb != 2'b00);
    assign cnt_dec = x_p_valid_reg && x_p_ready;

    // A response handshake with nothing outstanding is tolerated and leaves the count at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_reg <= '0;
        end else if (cnt_inc && !cnt_dec && (outstanding_reg != MaxCnt)) begin
            outstanding_reg <= outstanding_reg + 1'b1;
        end else if (cnt_dec && !cnt_inc && (outstanding_reg != '0)) begin
            outstanding_reg <= outstanding_reg - 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_x_c_adapter.sv
// Directed bench for acc_x_c_adapter with four accelerators and at most two outstanding write-backs.
module tb_acc_x_c_adapter;

    localparam int DW = 32;
    localparam int NA = 4;
    localparam int AW = 2;
    localparam logic [31:0] HART = 32'h1234_5678;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [31:0]   hart_id_i = HART;
    logic [31:0]   x_q_instr_data = '0;
    logic [DW-1:0] x_q_rs1 = '0, x_q_rs2 = '0, x_q_rs3 = '0;
    logic [2:0]    x_q_rs_valid = '0;
    logic [1:0]    x_q_rd_clean = '0;
    logic          x_q_valid = 1'b0;
    logic          x_q_ready, x_k_accept;
    logic [1:0]    x_k_writeback;
    logic [DW-1:0] x_p_data0, x_p_data1;
    logic          x_p_dual_writeback, x_p_error, x_p_valid;
    logic [4:0]    x_p_rd;
    logic          x_p_ready = 1'b0;
    logic [31:0]   prd_q_instr_data;
    logic [NA-1:0] prd_p_accept = '0;
    logic [2*NA-1:0] prd_p_writeback = '0;
    logic [3*NA-1:0] prd_p_use_rs = '0;
    logic [AW-1:0] c_q_addr;
    logic [31:0]   c_q_data_op, c_q_hart_id;
    logic [DW-1:0] c_q_data_arga, c_q_data_argb, c_q_data_argc;
    logic          c_q_valid;
    logic          c_q_ready = 1'b0;
    logic [DW-1:0] c_p_data0 = '0, c_p_data1 = '0;
    logic          c_p_dual_writeback = 1'b0;
    logic [31:0]   c_p_hart_id = '0;
    logic [4:0]    c_p_rd = '0;
    logic          c_p_error = 1'b0, c_p_valid = 1'b0;
    logic          c_p_ready;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    acc_x_c_adapter #(.DataWidth(DW), .NumAcc(NA), .AddrWidth(AW), .MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hart_id_i(hart_id_i),
        .x_q_instr_data(x_q_instr_data), .x_q_rs1(x_q_rs1), .x_q_rs2(x_q_rs2), .x_q_rs3(x_q_rs3),
        .x_q_rs_valid(x_q_rs_valid), .x_q_rd_clean(x_q_rd_clean), .x_q_valid(x_q_valid),
        .x_q_ready(x_q_ready), .x_k_accept(x_k_accept), .x_k_writeback(x_k_writeback),
        .x_p_data0(x_p_data0), .x_p_data1(x_p_data1), .x_p_dual_writeback(x_p_dual_writeback),
        .x_p_rd(x_p_rd), .x_p_error(x_p_error), .x_p_valid(x_p_valid), .x_p_ready(x_p_ready),
        .prd_q_instr_data(prd_q_instr_data), .prd_p_accept(prd_p_accept),
        .prd_p_writeback(prd_p_writeback), .prd_p_use_rs(prd_p_use_rs),
        .c_q_addr(c_q_addr), .c_q_data_op(c_q_data_op), .c_q_data_arga(c_q_data_arga),
        .c_q_data_argb(c_q_data_argb), .c_q_data_argc(c_q_data_argc), .c_q_hart_id(c_q_hart_id),
        .c_q_valid(c_q_valid), .c_q_ready(c_q_ready),
        .c_p_data0(c_p_data0), .c_p_data1(c_p_data1), .c_p_dual_writeback(c_p_dual_writeback),
        .c_p_hart_id(c_p_hart_id), .c_p_rd(c_p_rd), .c_p_error(c_p_error),
        .c_p_valid(c_p_valid), .c_p_ready(c_p_ready)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_c_q_valid: got %b expected 0", c_q_valid); end
        vec_cnt++; if (x_p_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_x_p_valid: got %b expected 0", x_p_valid); end
        vec_cnt++; if (dut.outstanding_reg !== 2'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d expected 0", dut.outstanding_reg); end
        vec_cnt++; if (x_p_data0 !== 32'h0) begin err_cnt++; $display("FAIL reset_x_p_data0: got %h expected 0", x_p_data0); end
        rst_ni = 1'b1;
        $display("reset released");
    endtask

    task automatic test_simple_offload();
        tick();
        x_q_instr_data = 32'h0000_100B; x_q_rs1 = 32'h1111_1111; x_q_rs2 = 32'h2222_2222; x_q_rs3 = 32'h3333_3333;
        prd_p_accept = 4'b0100; prd_p_writeback = 8'h10; prd_p_use_rs = 12'h0C0;
        x_q_rs_valid = 3'b011; x_q_rd_clean = 2'b01; x_q_valid = 1'b1; c_q_ready = 1'b1; x_p_ready = 1'b1;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b1) begin err_cnt++; $display("FAIL simple_ready: got %b expected 1", x_q_ready); end
        vec_cnt++; if (x_k_accept !== 1'b1) begin err_cnt++; $display("FAIL simple_accept: got %b expected 1", x_k_accept); end
        vec_cnt++; if (x_k_writeback !== 2'b01) begin err_cnt++; $display("FAIL simple_wb: got %b expected 01", x_k_writeback); end
        vec_cnt++; if (prd_q_instr_data !== 32'h0000_100B) begin err_cnt++; $display("FAIL simple_prd_instr: got %h expected 0000100b", prd_q_instr_data); end
        tick();
        x_q_valid = 1'b0;
        vec_cnt++; if (c_q_valid !== 1'b1) begin err_cnt++; $display("FAIL simple_c_q_valid: got %b expected 1", c_q_valid); end
        vec_cnt++; if (c_q_addr !== 2'd2) begin err_cnt++; $display("FAIL simple_addr: got %0d expected 2", c_q_addr); end
        vec_cnt++; if (c_q_hart_id !== HART) begin err_cnt++; $display("FAIL simple_hart: got %h expected %h", c_q_hart_id, HART); end
        vec_cnt++; if (c_q_data_op !== 32'h0000_100B) begin err_cnt++; $display("FAIL simple_op: got %h expected 0000100b", c_q_data_op); end
        vec_cnt++; if (c_q_data_argb !== 32'h2222_2222) begin err_cnt++; $display("FAIL simple_argb: got %h expected 22222222", c_q_data_argb); end
        vec_cnt++; if (dut.outstanding_reg !== 2'd1) begin err_cnt++; $display("FAIL simple_cnt: got %0d expected 1", dut.outstanding_reg); end
        // Retire the write-back so the count returns to zero.
        c_p_valid = 1'b1; c_p_hart_id = HART; c_p_data0 = 32'h0000_00AA; c_p_rd = 5'd3;
        tick();
        c_p_valid = 1'b0;
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL simple_c_q_drain: got %b expected 0", c_q_valid); end
        vec_cnt++; if (x_p_data0 !== 32'h0000_00AA) begin err_cnt++; $display("FAIL simple_rsp_data: got %h expected 000000aa", x_p_data0); end
        tick();
        vec_cnt++; if (dut.outstanding_reg !== 2'd0) begin err_cnt++; $display("FAIL simple_cnt_dec: got %0d expected 0", dut.outstanding_reg); end
        vec_cnt++; if (x_p_valid !== 1'b0) begin err_cnt++; $display("FAIL simple_x_p_drop: got %b expected 0", x_p_valid); end
        $display("simple offload to acc 2 done");
    endtask

    task automatic test_reject();
        prd_p_accept = 4'b0000; x_q_valid = 1'b1;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b1) begin err_cnt++; $display("FAIL reject_ready: got %b expected 1", x_q_ready); end
        vec_cnt++; if (x_k_accept !== 1'b0) begin err_cnt++; $display("FAIL reject_accept: got %b expected 0", x_k_accept); end
        vec_cnt++; if (x_k_writeback !== 2'b00) begin err_cnt++; $display("FAIL reject_wb: got %b expected 00", x_k_writeback); end
        tick();
        x_q_valid = 1'b0;
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL reject_c_q_valid: got %b expected 0", c_q_valid); end
        $display("reject with no accepting predecoder done");
    endtask

    task automatic test_operand_stall();
        prd_p_accept = 4'b0001; prd_p_writeback = 8'h00; prd_p_use_rs = 12'h007;
        x_q_rs_valid = 3'b011; x_q_rs3 = 32'h3C3C_3C3C; x_q_valid = 1'b1;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready: got %b expected 0", x_q_ready); end
        vec_cnt++; if (x_k_accept !== 1'b0) begin err_cnt++; $display("FAIL stall_accept: got %b expected 0", x_k_accept); end
        tick();
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_no_req: got %b expected 0", c_q_valid); end
        x_q_rs_valid = 3'b111;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_release_ready: got %b expected 1", x_q_ready); end
        vec_cnt++; if (x_k_accept !== 1'b1) begin err_cnt++; $display("FAIL stall_release_accept: got %b expected 1", x_k_accept); end
        tick();
        x_q_valid = 1'b0;
        vec_cnt++; if (c_q_addr !== 2'd0) begin err_cnt++; $display("FAIL stall_addr: got %0d expected 0", c_q_addr); end
        vec_cnt++; if (c_q_data_argc !== 32'h3C3C_3C3C) begin err_cnt++; $display("FAIL stall_argc: got %h expected 3c3c3c3c", c_q_data_argc); end
        vec_cnt++; if (dut.outstanding_reg !== 2'd0) begin err_cnt++; $display("FAIL stall_cnt: got %0d expected 0", dut.outstanding_reg); end
        tick();
        $display("operand stall released on rs3 valid");
    endtask

    task automatic test_response();
        x_p_ready = 1'b0;
        c_p_valid = 1'b1; c_p_hart_id = HART; c_p_data0 = 32'hDEAD_BEEF; c_p_data1 = 32'h1;
        c_p_rd = 5'd5; c_p_dual_writeback = 1'b1; c_p_error = 1'b0;
        #1;
        vec_cnt++; if (c_p_ready !== 1'b1) begin err_cnt++; $display("FAIL rsp_c_p_ready_idle: got %b expected 1", c_p_ready); end
        tick();
        c_p_data0 = 32'hCAFE_F00D; c_p_rd = 5'd9; c_p_dual_writeback = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++; if (x_p_valid !== 1'b1 || x_p_data0 !== 32'hDEAD_BEEF || x_p_data1 !== 32'h1 || x_p_rd !== 5'd5 || x_p_dual_writeback !== 1'b1)
                begin err_cnt++; $display("FAIL rsp_hold_%0d: got v=%b d0=%h d1=%h rd=%0d dual=%b expected v=1 d0=deadbeef d1=1 rd=5 dual=1", k, x_p_valid, x_p_data0, x_p_data1, x_p_rd, x_p_dual_writeback); end
            vec_cnt++; if (c_p_ready !== 1'b0) begin err_cnt++; $display("FAIL rsp_c_p_ready_hold_%0d: got %b expected 0", k, c_p_ready); end
            tick();
        end
        x_p_ready = 1'b1;
        #1;
        vec_cnt++; if (c_p_ready !== 1'b1) begin err_cnt++; $display("FAIL rsp_c_p_ready_release: got %b expected 1", c_p_ready); end
        tick();
        c_p_valid = 1'b0;
        vec_cnt++; if (x_p_valid !== 1'b1 || x_p_data0 !== 32'hCAFE_F00D || x_p_rd !== 5'd9) begin err_cnt++; $display("FAIL rsp_second: got v=%b d0=%h rd=%0d expected v=1 d0=cafef00d rd=9", x_p_valid, x_p_data0, x_p_rd); end
        tick();
        vec_cnt++; if (x_p_valid !== 1'b0) begin err_cnt++; $display("FAIL rsp_drain: got %b expected 0", x_p_valid); end
        vec_cnt++; if (dut.outstanding_reg !== 2'd0) begin err_cnt++; $display("FAIL rsp_cnt_floor: got %0d expected 0", dut.outstanding_reg); end
        $display("response path with backpressure done");
    endtask

    task automatic test_mismatch();
        x_p_ready = 1'b1; c_p_valid = 1'b1; c_p_hart_id = HART ^ 32'h1; c_p_data0 = 32'h5555_5555;
        #1;
        vec_cnt++; if (c_p_ready !== 1'b1) begin err_cnt++; $display("FAIL mismatch_ready: got %b expected 1", c_p_ready); end
        tick();
        c_p_valid = 1'b0;
        vec_cnt++; if (x_p_valid !== 1'b0) begin err_cnt++; $display("FAIL mismatch_dropped: got %b expected 0", x_p_valid); end
        $display("foreign-hart response dropped");
    endtask

    task automatic test_limit();
        prd_p_accept = 4'b0010; prd_p_writeback = 8'h04; prd_p_use_rs = 12'h000;
        x_q_rs_valid = 3'b000; x_q_rd_clean = 2'b01; x_q_valid = 1'b1; c_q_ready = 1'b1; x_p_ready = 1'b0;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b1) begin err_cnt++; $display("FAIL limit_first: got %b expected 1", x_q_ready); end
        tick();
        vec_cnt++; if (x_q_ready !== 1'b1) begin err_cnt++; $display("FAIL limit_second: got %b expected 1", x_q_ready); end
        tick();
        vec_cnt++; if (dut.outstanding_reg !== 2'd2) begin err_cnt++; $display("FAIL limit_cnt_full: got %0d expected 2", dut.outstanding_reg); end
        vec_cnt++; if (x_q_ready !== 1'b0 || x_k_accept !== 1'b0) begin err_cnt++; $display("FAIL limit_third_stall: got ready=%b accept=%b expected 0 0", x_q_ready, x_k_accept); end
        tick();
        vec_cnt++; if (x_q_ready !== 1'b0) begin err_cnt++; $display("FAIL limit_still_stalled: got %b expected 0", x_q_ready); end
        c_p_valid = 1'b1; c_p_hart_id = HART; c_p_data0 = 32'h0BAD_F00D;
        tick();
        c_p_valid = 1'b0;
        vec_cnt++; if (x_p_valid !== 1'b1) begin err_cnt++; $display("FAIL limit_rsp_valid: got %b expected 1", x_p_valid); end
        x_p_ready = 1'b1;
        #1;
        vec_cnt++; if (x_q_ready !== 1'b0) begin err_cnt++; $display("FAIL limit_handshake_cycle: got %b expected 0", x_q_ready); end
        tick();
        x_p_ready = 1'b0;
        vec_cnt++; if (dut.outstanding_reg !== 2'd1) begin err_cnt++; $display("FAIL limit_cnt_dec: got %0d expected 1", dut.outstanding_reg); end
        vec_cnt++; if (x_q_ready !== 1'b1 || x_k_accept !== 1'b1) begin err_cnt++; $display("FAIL limit_resume: got ready=%b accept=%b expected 1 1", x_q_ready, x_k_accept); end
        tick();
        x_q_valid = 1'b0;
        vec_cnt++; if (dut.outstanding_reg !== 2'd2 || c_q_valid !== 1'b1) begin err_cnt++; $display("FAIL limit_final: got cnt=%0d c_q_valid=%b expected 2 1", dut.outstanding_reg, c_q_valid); end
        $display("outstanding limit enforced and released");
    endtask

    task automatic test_reset_mid_op();
        c_q_ready = 1'b0;
        c_p_valid = 1'b1; c_p_hart_id = HART; c_p_data0 = 32'h7777_7777;
        tick();
        c_p_valid = 1'b0;
        vec_cnt++; if (c_q_valid !== 1'b1 || x_p_valid !== 1'b1 || dut.outstanding_reg !== 2'd2) begin err_cnt++; $display("FAIL midrst_pre: got c_q_valid=%b x_p_valid=%b cnt=%0d expected 1 1 2", c_q_valid, x_p_valid, dut.outstanding_reg); end
        #2 rst_ni = 1'b0;
        #1;
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_c_q_valid: got %b expected 0", c_q_valid); end
        vec_cnt++; if (x_p_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_x_p_valid: got %b expected 0", x_p_valid); end
        vec_cnt++; if (dut.outstanding_reg !== 2'd0) begin err_cnt++; $display("FAIL midrst_cnt: got %0d expected 0", dut.outstanding_reg); end
        vec_cnt++; if (c_q_addr !== 2'd0 || x_p_data0 !== 32'h0) begin err_cnt++; $display("FAIL midrst_data: got addr=%0d d0=%h expected 0 0", c_q_addr, x_p_data0); end
        tick();
        rst_ni = 1'b1;
        tick();
        vec_cnt++; if (c_q_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_after: got %b expected 0", c_q_valid); end
        $display("asynchronous reset mid-operation done");
    endtask

    initial begin
        test_reset();
        test_simple_offload();
        test_reject();
        test_operand_stall();
        test_response();
        test_mismatch();
        test_limit();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
